// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;

  // Clear-sweep controller states
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Default geometry: 32 entries of 32 bits, two read ports
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_N_RD   = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: address mux over the flattened storage, zero-register mask,
// and an optional output register with write-first bypass.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    mem_flat,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic                             commit_en,
  input  logic [ADDR_W-1:0]                commit_addr,
  input  logic [DATA_W/8-1:0]              commit_be,
  input  logic [DATA_W-1:0]                commit_data,
  output logic [DATA_W-1:0]                rdata
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] raw_data;
  logic [DATA_W-1:0] merged_data;
  logic [DATA_W-1:0] comb_data;
  logic [DATA_W-1:0] rdata_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              is_zero;
  logic              hit;

  assign raw_data = mem_flat[int'(raddr)*DATA_W +: DATA_W];
  assign is_zero  = (ZERO_REG != 0) && (raddr == '0);
  assign hit      = commit_en && (commit_addr == raddr);

  // Byte-merge of the value being committed this edge over the current contents
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign merged_data[gi*8 +: 8] = commit_be[gi] ? commit_data[gi*8 +: 8]
                                                    : raw_data[gi*8 +: 8];
    end
  endgenerate

  assign comb_data  = is_zero ? '0 : raw_data;
  assign rdata_next = is_zero ? '0 : (hit ? merged_data : raw_data);

  // Registered read: write-first, so a same-edge write is seen immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  // RD_REG is constant, so synthesis keeps only the selected path
  assign rdata = (RD_REG != 0) ? rdata_reg : comb_data;

endmodule

// File: rtl/regfile_np.sv
// Parametrised multi-port register file with byte-enabled writes, optional
// hard-wired zero entry, optional registered reads and a sequenced clear sweep.
module regfile_np
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = RF_N_RD,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [N_RD*ADDR_W-1:0]   raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  input  logic                     clr,
  output logic                     busy
);

  localparam int               DEPTH    = 2**ADDR_W;
  localparam int               NBYTES   = DATA_W / 8;
  localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  rf_state_t           state_reg;
  logic [ADDR_W:0]     cnt_reg;
  logic                busy_reg;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  logic                clearing;
  logic                wr_ok;
  logic                commit_en;
  logic [ADDR_W-1:0]   commit_addr;
  logic [NBYTES-1:0]   commit_be;
  logic [DATA_W-1:0]   commit_data;

  // The sweep owns the write path while it runs; user writes are ignored then.
  assign clearing    = (state_reg == RF_CLEAR);
  assign wr_ok       = we && !clearing && !((ZERO_REG != 0) && (waddr == '0));
  assign commit_en   = clearing || wr_ok;
  assign commit_addr = clearing ? cnt_reg[ADDR_W-1:0] : waddr;
  assign commit_be   = clearing ? '1 : wbe;
  assign commit_data = clearing ? '0 : wdata;

  // Clear-sweep controller: one entry per cycle, busy is a registered flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RF_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RF_IDLE: begin
          if (clr) begin
            state_reg <= RF_CLEAR;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          if (cnt_reg == LAST_IDX) begin
            state_reg <= RF_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= RF_IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  // Storage: each entry is its own register so reset can clear everything at once
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Byte-enabled update of this entry when the commit targets it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[gi] <= '0;
        end else if (commit_en && (commit_addr == ADDR_W'(gi))) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (commit_be[b]) begin
              mem[gi][b*8 +: 8] <= commit_data[b*8 +: 8];
            end
          end
        end
      end
      assign mem_flat[gi*DATA_W +: DATA_W] = mem[gi];
    end

    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .RD_REG   (RD_REG)
      ) u_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_flat    (mem_flat),
        .raddr       (raddr[gi*ADDR_W +: ADDR_W]),
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_be   (commit_be),
        .commit_data (commit_data),
        .rdata       (rdata[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_np.sv
// Directed bench for regfile_np: one combinational-read and one registered-read
// instance share all inputs; expected read data flows through a scoreboard queue.
module tb_regfile_np;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wbe;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        clr;
  logic [63:0] rdata_c;
  logic [63:0] rdata_r;
  logic        busy_c;
  logic        busy_r;

  int n_checks;
  int n_errors;

  logic [31:0] mem_m [32];
  logic [31:0] exp_q [$];
  string       tag_q [$];

  regfile_np #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .RD_REG(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_c), .clr(clr), .busy(busy_c)
  );

  regfile_np #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .RD_REG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_r), .clr(clr), .busy(busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty: observed %h expected none", act);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, act, e);
    end
  endtask

  task automatic mwrite(input int a, input logic [31:0] d, input logic [3:0] be);
    if (a != 0) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    we    = 1'b1;
    waddr = 5'(a);
    wdata = d;
    wbe   = be;
    tick();
    mwrite(a, d, be);
    we = 1'b0;
    $display("wr   addr=%0d data=%h be=%b", a, d, be);
  endtask

  // Port 0 reads a0, port 1 reads a1; comb results checked before the edge,
  // registered results after it.
  task automatic rd_chk(input int a0, input int a1);
    raddr = {5'(a1), 5'(a0)};
    push($sformatf("comb_p0@%0d", a0), mem_m[a0]);
    push($sformatf("comb_p1@%0d", a1), mem_m[a1]);
    push($sformatf("reg_p0@%0d", a0), mem_m[a0]);
    push($sformatf("reg_p1@%0d", a1), mem_m[a1]);
    #1;
    pop_chk(rdata_c[31:0]);
    pop_chk(rdata_c[63:32]);
    tick();
    pop_chk(rdata_r[31:0]);
    pop_chk(rdata_r[63:32]);
    $display("rd   p0=%0d:%h p1=%0d:%h", a0, rdata_c[31:0], a1, rdata_c[63:32]);
  endtask

  // Counts busy cycles after the edge that samples clr, bounded.
  task automatic sweep_len(output int cnt);
    cnt = 0;
    while (busy_c && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] old20;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    wbe   = 4'h0;
    waddr = 5'd0;
    wdata = 32'h0;
    raddr = 10'd0;
    clr   = 1'b0;
    mclear();

    // Reset state
    #3;
    chk("rst_busy_c", 32'(busy_c), 32'd0);
    chk("rst_busy_r", 32'(busy_r), 32'd0);
    chk("rst_rdata_r0", rdata_r[31:0], 32'h0);
    chk("rst_rdata_r1", rdata_r[63:32], 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Everything reads 0 before any write
    for (int i = 0; i < 32; i += 4) rd_chk(i, 31 - i);

    // Fill 1..31 with data = address, read ascending / descending
    for (int a = 1; a < 32; a++) wr(a, 32'(a), 4'hF);
    for (int i = 0; i < 32; i++) rd_chk(i, 31 - i);

    // Zero register drops writes
    wr(0, 32'hDEADBEEF, 4'hF);
    rd_chk(0, 0);
    chk("zero_const", rdata_c[31:0], 32'h0);

    // Byte enables
    wr(5, 32'h11223344, 4'hF);
    wr(5, 32'hAABBCCDD, 4'b0101);
    rd_chk(5, 5);
    chk("be_const", rdata_c[31:0], 32'h11BB33DD);

    // Same-edge write and read of address 7
    raddr = {5'd0, 5'd7};
    we = 1'b1; waddr = 5'd7; wdata = 32'h55; wbe = 4'hF;
    #1;
    chk("comb_no_bypass", rdata_c[31:0], 32'd7);
    tick();
    mwrite(7, 32'h55, 4'hF);
    we = 1'b0;
    chk("reg_bypass", rdata_r[31:0], 32'h55);
    chk("comb_after_edge", rdata_c[31:0], 32'h55);
    $display("byp  addr=7 reg=%h comb=%h", rdata_r[31:0], rdata_c[31:0]);

    // Clear sweep with a write held on address 3 and a repeated clr mid-sweep
    for (int a = 0; a < 32; a++) wr(a, {8'(a), 8'hA5, 8'(~a), 8'h3C}, 4'hF);
    rd_chk(20, 3);
    old20 = mem_m[20];
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy_c", 32'(busy_c), 32'd1);
    chk("clr_busy_r", 32'(busy_r), 32'd1);
    we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    raddr = {5'd20, 5'd5};
    cnt = 0;
    while (busy_c && cnt < 40) begin
      if (cnt == 5) clr = 1'b1;
      tick();
      clr = 1'b0;
      cnt++;
      if (cnt == 10) begin
        chk("mid_cleared_c", rdata_c[31:0], 32'h0);
        chk("mid_old_c", rdata_c[63:32], old20);
        chk("mid_cleared_r", rdata_r[31:0], 32'h0);
        chk("mid_old_r", rdata_r[63:32], old20);
      end
    end
    we = 1'b0;
    chk("sweep_len", 32'(cnt), 32'd32);
    chk("sweep_busy_r", 32'(busy_r), 32'd0);
    $display("clr  busy_cycles=%0d", cnt);
    mclear();
    for (int i = 0; i < 32; i++) rd_chk(i, 31 - i);

    // Reset in the middle of a sweep
    wr(9, 32'h99, 4'hF);
    wr(30, 32'h3030, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    chk("pre_rst_busy", 32'(busy_c), 32'd1);
    raddr = {5'd30, 5'd9};
    #1;
    chk("pre_rst_old30", rdata_c[63:32], 32'h3030);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_c", 32'(busy_c), 32'd0);
    chk("mid_rst_busy_r", 32'(busy_r), 32'd0);
    chk("mid_rst_c1", rdata_c[63:32], 32'h0);
    chk("mid_rst_r0", rdata_r[31:0], 32'h0);
    chk("mid_rst_r1", rdata_r[63:32], 32'h0);
    mclear();
    #1;
    rst_n = 1'b1;
    tick();
    $display("rst  mid-sweep abort");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sweep_len(cnt);
    chk("sweep_len_after_rst", 32'(cnt), 32'd32);
    $display("clr  busy_cycles=%0d", cnt);
    rd_chk(9, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_np.md
# regfile_np

Parametrised multi-port register file; the successor to the fixed 32x32, 2-read/1-write register file in the datapath experiments. Adds configurable width, depth and read-port count, per-byte write enables, an optional hard-wired zero register, a registered-read mode with write-first bypass, and a sequenced clear operation with a busy flag. It sits between the decode stage (read addresses) and the writeback stage (write port) of the CPU datapath.

## Interface
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 5: address width; `DEPTH = 2**ADDR_W` entries.
- `N_RD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 1: 1 makes entry 0 read as 0 and ignore writes.
- `RD_REG`, 0: 0 gives combinational reads; 1 gives registered reads with 1-cycle latency.

Ports:
- `clk`  in  1  the single clock; rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `we`  in  1  write enable.
- `wbe`  in  DATA_W/8  byte enables; bit i covers `wdata[8i+7:8i]`.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `raddr`  in  N_RD*ADDR_W  packed read addresses; port k uses `[k*ADDR_W +: ADDR_W]`.
- `rdata`  out  N_RD*DATA_W  packed read data; port k uses `[k*DATA_W +: DATA_W]`.
- `clr`  in  1  single-cycle request to start a clear sweep.
- `busy`  out  1  high while the clear sweep runs.

## Operation
- Reset (`rst_n`=0): all entries 0, registered `rdata` 0, `busy` 0, FSM in IDLE, sweep counter 0. Takes effect immediately.
- Write: on a rising edge with `we`=1 and `busy`=0, update each byte of `mem[waddr]` whose `wbe` bit is 1; other bytes hold. If `ZERO_REG`=1 and `waddr`=0, the write is dropped. `we` is ignored while `busy`=1.
- Read, `RD_REG`=0: `rdata[k] = mem[raddr[k]]` combinationally. A write becomes visible after the edge that commits it; there is no same-cycle bypass.
- Read, `RD_REG`=1: on each edge `rdata[k]` loads `mem[raddr[k]]`. If that edge also commits a write to the same address, the loaded value is the byte-merged new value (write-first).
- Zero register: reads of address 0 always return 0 when `ZERO_REG`=1.
- Ports are independent. Any ports may share an address and return identical data.
- FSM states:
  - IDLE: `busy`=0. `clr`=1 moves to CLEAR with counter 0.
  - CLEAR: `busy`=1. Each cycle writes 0 to `mem[counter]` and increments the counter. After the edge that clears entry DEPTH-1, returns to IDLE and the counter wraps to 0.
- `clr` while in CLEAR is ignored; it neither restarts nor extends the sweep.
- Reads during CLEAR return current contents: cleared entries read 0, uncleared entries read their old values.

## Timing
- Write latency: data is written at the edge where `we` is sampled.
- Read latency: 0 cycles for `RD_REG`=0, 1 cycle for `RD_REG`=1.
- `clr` sampled at edge T: `busy` goes high after T. Entries 0..DEPTH-1 are cleared at edges T+1..T+DEPTH. `busy` goes low after edge T+DEPTH.
- `clr`=1 and `we`=1 at the same edge in IDLE: the write commits at that edge, then the sweep clears it.
- `rst_n` asserted mid-sweep: the sweep aborts immediately and every output returns to its reset value.
- Address wrap: the counter is ADDR_W+1 bits wide; the terminal condition is counter = DEPTH-1.

## Structure
- `regfile_pkg`: FSM state enum (`RF_IDLE`, `RF_CLEAR`) and default parameter constants (`RF_DATA_W`, `RF_ADDR_W`, `RF_N_RD`).
- Sub-module `regfile_rd_port`: one read port, containing the address mux, the zero-register mask, and the optional output register with write-first bypass. It is instantiated N_RD times via generate. The storage array, write logic and clear FSM stay in `regfile_np`.

## Test plan
- Reset and basic write/read, defaults, `RD_REG`=0: write addresses 1..31 with data = address, read port 0 ascending and port 1 descending. `rdata` matches the address; all reads return 0 before any write.
- Zero register: write 0xDEADBEEF to address 0, then read address 0. Result is 0x00000000, with `ZERO_REG`=1.
- Byte enables: write 0x11223344 to address 5, then write 0xAABBCCDD with `wbe`=4'b0101. Address 5 reads 0x11BB33DD.
- Bypass, `RD_REG`=1: write 0x55 to address 7 while `raddr[0]`=7 on the same edge. `rdata[0]`=0x55 on the next cycle; with `RD_REG`=0, `rdata` is 0x55 only after the edge.
- Clear sweep: fill all entries, pulse `clr`, hold `we`=1 to address 3 during the sweep. `busy` is high for exactly 32 cycles, the write is dropped, and all entries read 0 afterwards.
- Reset mid-sweep: pulse `clr`, then assert `rst_n`=0 after 10 cycles. `busy` drops immediately and all reads return 0. A `clr` issued after release completes in 32 cycles.
